// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with C/DC/Z status and iterative shift-and-add multiply
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter int DC_BIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flag_wr,
  input  logic [2:0]       flag_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             c_flag,
  output logic             dc_flag,
  output logic             z_flag,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_MOV  = 4'd0;
  localparam logic [3:0] OP_SWAP = 4'd1;
  localparam logic [3:0] OP_CLR  = 4'd2;
  localparam logic [3:0] OP_RLF  = 4'd3;
  localparam logic [3:0] OP_RRF  = 4'd4;
  localparam logic [3:0] OP_IOR  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_COMP = 4'd8;
  localparam logic [3:0] OP_ADD  = 4'd9;
  localparam logic [3:0] OP_SUB  = 4'd10;
  localparam logic [3:0] OP_INC  = 4'd11;
  localparam logic [3:0] OP_DEC  = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t               state_q, state_d;
  logic                 rdy_q, rdy_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 mul_fin_q, mul_fin_d;
  logic                 pend_q, pend_d;
  logic [3:0]           pop_q, pop_d;
  logic [WIDTH-1:0]     pa_q, pa_d;
  logic [WIDTH-1:0]     pb_q, pb_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     result_hi_q, result_hi_d;
  logic                 c_q, c_d;
  logic                 dc_q, dc_d;
  logic                 z_q, z_d;
  logic                 out_valid_q, out_valid_d;

  logic                 xfer;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       arith;
  logic [WIDTH-1:0]     res;
  logic [WIDTH-1:0]     pb_n;
  logic                 upd_z;

  // rdy_q keeps in_ready low until the first edge after reset release
  assign in_ready  = rdy_q & (state_q == S_IDLE);
  assign busy      = (state_q == S_MUL);
  assign xfer      = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign c_flag    = c_q;
  assign dc_flag   = dc_q;
  assign z_flag    = z_q;
  assign pb_n      = ~pb_q;

  // Control: accept ops, run one multiply bit per cycle while in S_MUL
  always_comb begin
    state_d   = state_q;
    rdy_d     = 1'b1;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    mul_fin_d = 1'b0;
    pend_d    = 1'b0;
    pop_d     = pop_q;
    pa_d      = pa_q;
    pb_d      = pb_q;
    mul_sum   = '0;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          if (op == OP_MUL) begin
            state_d = S_MUL;
            cnt_d   = '0;
            mcand_d = op_a;
            prod_d  = {{WIDTH{1'b0}}, op_b};
          end else begin
            pend_d = 1'b1;
            pop_d  = op;
            pa_d   = op_a;
            pb_d   = op_b;
          end
        end
      end
      S_MUL: begin
        // Multiplier sits in the low half and shifts out as the product shifts in
        mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_d  = {mul_sum, prod_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d   = S_IDLE;
          mul_fin_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: evaluate the op captured last edge, using C as it stands now
  always_comb begin
    result_d    = result_q;
    result_hi_d = result_hi_q;
    c_d         = c_q;
    dc_d        = dc_q;
    z_d         = z_q;
    out_valid_d = 1'b0;
    arith       = '0;
    res         = '0;
    upd_z       = 1'b0;
    if (mul_fin_q) begin
      out_valid_d = 1'b1;
      result_d    = prod_q[WIDTH-1:0];
      result_hi_d = prod_q[2*WIDTH-1:WIDTH];
      z_d         = (prod_q == '0);
      c_d         = |prod_q[2*WIDTH-1:WIDTH];
    end else if (pend_q) begin
      out_valid_d = 1'b1;
      result_hi_d = '0;
      case (pop_q)
        OP_MOV:  begin res = pa_q; upd_z = 1'b1; end
        OP_SWAP: res = {pa_q[WIDTH/2-1:0], pa_q[WIDTH-1:WIDTH/2]};
        OP_CLR:  begin res = '0; upd_z = 1'b1; end
        OP_RLF:  begin res = {pa_q[WIDTH-2:0], c_q}; c_d = pa_q[WIDTH-1]; end
        OP_RRF:  begin res = {c_q, pa_q[WIDTH-1:1]}; c_d = pa_q[0]; end
        OP_IOR:  begin res = pa_q | pb_q; upd_z = 1'b1; end
        OP_AND:  begin res = pa_q & pb_q; upd_z = 1'b1; end
        OP_XOR:  begin res = pa_q ^ pb_q; upd_z = 1'b1; end
        OP_COMP: begin res = ~pa_q; upd_z = 1'b1; end
        OP_ADD: begin
          arith = {1'b0, pa_q} + {1'b0, pb_q};
          res   = arith[WIDTH-1:0];
          c_d   = arith[WIDTH];
          // carry into bit DC_BIT+1 recovered from the sum bit and both operand bits
          dc_d  = arith[DC_BIT+1] ^ pa_q[DC_BIT+1] ^ pb_q[DC_BIT+1];
          upd_z = 1'b1;
        end
        OP_SUB: begin
          arith = {1'b0, pa_q} + {1'b0, pb_n} + (WIDTH+1)'(1);
          res   = arith[WIDTH-1:0];
          c_d   = arith[WIDTH];
          dc_d  = arith[DC_BIT+1] ^ pa_q[DC_BIT+1] ^ pb_n[DC_BIT+1];
          upd_z = 1'b1;
        end
        OP_INC:  begin res = pa_q + WIDTH'(1); upd_z = 1'b1; end
        OP_DEC:  begin res = pa_q - WIDTH'(1); upd_z = 1'b1; end
        default: res = '0;
      endcase
      result_d = res;
      if (upd_z) z_d = (res == '0);
    end
    // A direct status write overrides any ALU flag update on the same edge
    if (flag_wr) {c_d, dc_d, z_d} = flag_in;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rdy_q       <= 1'b0;
      cnt_q       <= '0;
      mcand_q     <= '0;
      prod_q      <= '0;
      mul_fin_q   <= 1'b0;
      pend_q      <= 1'b0;
      pop_q       <= '0;
      pa_q        <= '0;
      pb_q        <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      c_q         <= 1'b0;
      dc_q        <= 1'b0;
      z_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
      mul_fin_q   <= mul_fin_d;
      pend_q      <= pend_d;
      pop_q       <= pop_d;
      pa_q        <= pa_d;
      pb_q        <= pb_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      c_q         <= c_d;
      dc_q        <= dc_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
